// File: rtl/rounding_unit_arbiter.sv
// Round-robin arbiter sharing one rounding_unit among NUM_REQ normalizing datapaths.
// S1 registers drive the rounding_unit; S2 captures its result with tag and source for downstream.
module rounding_unit_arbiter #(
    parameter int  NUM_REQ   = 3,
    parameter int  TAG_WIDTH = 4,
    localparam int SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           flush_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ-1:0]             req_normalize_i,
    input  logic [NUM_REQ-1:0]             req_rounding_mode_i,
    input  logic [2*NUM_REQ-1:0]           req_sticky_bit_select_i,
    input  logic [10*NUM_REQ-1:0]          req_exponent_i,
    input  logic [49*NUM_REQ-1:0]          req_fraction_i,
    input  logic [27*NUM_REQ-1:0]          req_remainder_i,
    input  logic [TAG_WIDTH*NUM_REQ-1:0]   req_tag_i,
    output logic                           ru_normalize_o,
    output logic                           ru_rounding_mode_o,
    output logic [1:0]                     ru_sticky_bit_select_o,
    output logic [9:0]                     ru_normalized_exponent_o,
    output logic [48:0]                    ru_normalized_fraction_o,
    output logic [26:0]                    ru_remainder_o,
    input  logic [9:0]                     ru_result_exponent_i,
    input  logic [31:0]                    ru_result_fraction_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [9:0]                     out_exponent_o,
    output logic [31:0]                    out_fraction_o,
    output logic [TAG_WIDTH-1:0]           out_tag_o,
    output logic [SRC_W-1:0]               out_source_o
);

    typedef struct packed {
        logic                 normalize;
        logic                 rmode;
        logic [1:0]           sticky;
        logic [9:0]           exp;
        logic [48:0]          frac;
        logic [26:0]          rem;
        logic [TAG_WIDTH-1:0] tag;
        logic [SRC_W-1:0]     src;
    } s1_t;

    typedef struct packed {
        logic [9:0]           exp;
        logic [31:0]          frac;
        logic [TAG_WIDTH-1:0] tag;
        logic [SRC_W-1:0]     src;
    } s2_t;

    s1_t              cand [NUM_REQ];
    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_any, grant_vld;
    logic             s1_free, s2_free;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign cand[g] = {req_normalize_i[g], req_rounding_mode_i[g],
                          req_sticky_bit_select_i[2*g +: 2], req_exponent_i[10*g +: 10],
                          req_fraction_i[49*g +: 49], req_remainder_i[27*g +: 27],
                          req_tag_i[TAG_WIDTH*g +: TAG_WIDTH], SRC_W'(g)};
    end

    assign s2_free   = !out_valid_q || out_ready_i;
    assign s1_free   = !s1_valid_q || s2_free;
    assign grant_vld = grant_any && s1_free && !flush_i;

    // Search starts just after the last winner; pos stays below NUM_REQ so no
    // out-of-range requester slice is ever selected.
    always_comb begin
        int pos;
        pos       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(rr_ptr_q) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!grant_any && req_valid_i[SRC_W'(pos)]) begin
                grant_any = 1'b1;
                grant_idx = SRC_W'(pos);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_vld) req_ready_o[grant_idx] = 1'b1;
    end

    always_comb begin
        s1_d        = s1_q;
        s2_d        = s2_q;
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush_i) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (s2_free) begin
                out_valid_d = s1_valid_q;
                if (s1_valid_q) s2_d = {ru_result_exponent_i, ru_result_fraction_i, s1_q.tag, s1_q.src};
            end
            if (s1_free) begin
                s1_valid_d = grant_vld;
                if (grant_vld) begin
                    s1_d     = cand[grant_idx];
                    rr_ptr_d = grant_idx;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SRC_W'(NUM_REQ - 1);
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign ru_normalize_o           = s1_q.normalize;
    assign ru_rounding_mode_o       = s1_q.rmode;
    assign ru_sticky_bit_select_o   = s1_q.sticky;
    assign ru_normalized_exponent_o = s1_q.exp;
    assign ru_normalized_fraction_o = s1_q.frac;
    assign ru_remainder_o           = s1_q.rem;
    assign out_valid_o              = out_valid_q;
    assign out_exponent_o           = s2_q.exp;
    assign out_fraction_o           = s2_q.frac;
    assign out_tag_o                = s2_q.tag;
    assign out_source_o             = s2_q.src;

endmodule

// File: tb/tb_rounding_unit_arbiter.sv
// Directed bench for rounding_unit_arbiter: expected results are queued at issue time
// and a negedge monitor compares them whenever out_valid is presented.
module tb_rounding_unit_arbiter;
    localparam int N  = 3;
    localparam int TW = 4;

    logic          clk = 1'b0, reset_n = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [2:0]    req_valid = '0;
    logic [2:0]    req_ready;
    logic [2:0]    req_norm, req_mode;
    logic [5:0]    req_sticky;
    logic [29:0]   req_exp;
    logic [146:0]  req_frac;
    logic [80:0]   req_rem;
    logic [11:0]   req_tag;
    logic          ru_norm, ru_mode;
    logic [1:0]    ru_sticky;
    logic [9:0]    ru_exp, ru_res_e, out_exponent;
    logic [48:0]   ru_frac;
    logic [26:0]   ru_rem;
    logic [31:0]   ru_res_f, out_fraction;
    logic          out_valid;
    logic [TW-1:0] out_tag;
    logic [1:0]    out_source;

    rounding_unit_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_normalize_i(req_norm), .req_rounding_mode_i(req_mode),
        .req_sticky_bit_select_i(req_sticky), .req_exponent_i(req_exp),
        .req_fraction_i(req_frac), .req_remainder_i(req_rem), .req_tag_i(req_tag),
        .ru_normalize_o(ru_norm), .ru_rounding_mode_o(ru_mode),
        .ru_sticky_bit_select_o(ru_sticky), .ru_normalized_exponent_o(ru_exp),
        .ru_normalized_fraction_o(ru_frac), .ru_remainder_o(ru_rem),
        .ru_result_exponent_i(ru_res_e), .ru_result_fraction_i(ru_res_f),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_exponent_o(out_exponent), .out_fraction_o(out_fraction),
        .out_tag_o(out_tag), .out_source_o(out_source)
    );

    always #5 clk = ~clk;

    // Stand-in rounding unit: a fixed transform of the S1 registers.
    assign ru_res_e = ru_exp + 10'd1;
    assign ru_res_f = ru_frac[48:17] ^ {28'h0, ru_rem[3:0]};

    typedef struct packed {
        logic [9:0]  e;
        logic [31:0] f;
        logic [3:0]  t;
        logic [1:0]  s;
    } item_t;

    item_t       sb[$];
    int          n_chk = 0, n_fail = 0;
    int          gseq = 0;
    logic [9:0]  r_exp    [N];
    logic [48:0] r_frac   [N];
    logic [26:0] r_rem    [N];
    logic [3:0]  r_tag    [N];
    logic        r_norm   [N];
    logic        r_mode   [N];
    logic [1:0]  r_sticky [N];
    logic [89:0] s1_exp;
    logic        s1_pending = 1'b0;
    logic        fair_on = 1'b0;
    int          fair_gap = 0, fair_max = 0;

    always_comb begin
        req_exp = '0; req_frac = '0; req_rem = '0; req_tag = '0;
        req_norm = '0; req_mode = '0; req_sticky = '0;
        for (int i = 0; i < N; i++) begin
            req_exp[10*i +: 10]   = r_exp[i];
            req_frac[49*i +: 49]  = r_frac[i];
            req_rem[27*i +: 27]   = r_rem[i];
            req_tag[4*i +: 4]     = r_tag[i];
            req_norm[i]           = r_norm[i];
            req_mode[i]           = r_mode[i];
            req_sticky[2*i +: 2]  = r_sticky[i];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_data(input int i, input int s);
        r_exp[i]    = 10'(s * 37 + i * 100 + 5);
        r_frac[i]   = {17'(s * 13 + i), 32'(s * 32'h9E37_79B9 + 1)};
        r_rem[i]    = 27'(s * 77 + i * 5 + 1);
        r_tag[i]    = 4'(s);
        r_norm[i]   = s[0];
        r_mode[i]   = s[1] ^ i[0];
        r_sticky[i] = 2'(s + i);
    endtask

    // One clock: entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic [2:0] v, input logic ordy, input logic fl,
                         input logic [2:0] exp_rdy, input int ov);
        int acc;
        acc = -1;
        if (s1_pending) begin
            chk("s1_regs", {ru_norm, ru_mode, ru_sticky, ru_exp, ru_frac, ru_rem}, s1_exp);
            s1_pending = 1'b0;
        end
        if (ov >= 0) chk("out_valid", out_valid, ov[0]);
        req_valid = v; out_ready = ordy; flush = fl;
        #1;
        chk("req_ready", req_ready, exp_rdy);
        if (fair_on && req_ready != 3'b000) begin
            if (req_ready[2]) fair_gap = 0; else fair_gap++;
            if (fair_gap > fair_max) fair_max = fair_gap;
        end
        for (int i = 0; i < N; i++) if (exp_rdy[i]) acc = i;
        if (acc >= 0) begin
            sb.push_back('{e: r_exp[acc] + 10'd1,
                           f: r_frac[acc][48:17] ^ {28'h0, r_rem[acc][3:0]},
                           t: r_tag[acc], s: 2'(acc)});
            s1_exp = {r_norm[acc], r_mode[acc], r_sticky[acc], r_exp[acc], r_frac[acc], r_rem[acc]};
            s1_pending = 1'b1;
        end
        @(posedge clk);
        #1;
        if (fl) sb.delete();
        if (acc >= 0) begin
            gseq++;
            set_data(acc, gseq + 10);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req_valid = '0; flush = 1'b0; out_ready = 1'b1;
        sb.delete(); s1_pending = 1'b0;
        #2;
        chk("reset_out", {out_valid, out_exponent, out_fraction, out_tag, out_source, req_ready}, '0);
        chk("reset_ru", {ru_norm, ru_mode, ru_sticky, ru_exp, ru_frac, ru_rem}, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL out_unexpected: got tag %0h src %0d expected no output", out_tag, out_source);
                end else begin
                    chk("out_item", {out_exponent, out_fraction, out_tag, out_source}, sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < N; i++) set_data(i, i + 1);
        do_reset();

        // single requester, latency
        r_exp[1] = 10'h07F; r_frac[1] = 49'h0_8000_0000_0000; r_tag[1] = 4'h5;
        cycle(3'b010, 1, 0, 3'b010, 0);
        cycle(3'b000, 1, 0, 3'b000, 0);
        cycle(3'b000, 1, 0, 3'b000, 1);
        chk("t1_tag_src", {out_tag, out_source}, {4'h5, 2'd1});
        cycle(3'b000, 1, 0, 3'b000, 0);

        // all valid, full throughput
        do_reset();
        cycle(3'b111, 1, 0, 3'b001, 0);
        cycle(3'b111, 1, 0, 3'b010, 0);
        cycle(3'b111, 1, 0, 3'b100, 1);
        cycle(3'b111, 1, 0, 3'b001, 1);
        cycle(3'b111, 1, 0, 3'b010, 1);
        cycle(3'b111, 1, 0, 3'b100, 1);
        cycle(3'b000, 1, 0, 3'b000, 1);
        cycle(3'b000, 1, 0, 3'b000, 1);
        cycle(3'b000, 1, 0, 3'b000, 0);

        // backpressure
        do_reset();
        cycle(3'b111, 1, 0, 3'b001, 0);
        cycle(3'b111, 0, 0, 3'b010, 0);
        cycle(3'b111, 0, 0, 3'b000, 1);
        cycle(3'b111, 0, 0, 3'b000, 1);
        cycle(3'b111, 0, 0, 3'b000, 1);
        cycle(3'b111, 1, 0, 3'b100, 1);
        cycle(3'b000, 1, 0, 3'b000, 1);
        cycle(3'b000, 1, 0, 3'b000, 1);
        cycle(3'b000, 1, 0, 3'b000, 0);

        // flush with S1 and S2 full; rr_ptr=0 survives so 2 beats 0
        do_reset();
        cycle(3'b001, 1, 0, 3'b001, 0);
        cycle(3'b001, 0, 0, 3'b001, 0);
        cycle(3'b100, 0, 1, 3'b000, 1);
        cycle(3'b101, 1, 0, 3'b100, 0);
        cycle(3'b000, 1, 0, 3'b000, 0);
        cycle(3'b000, 1, 0, 3'b000, 1);
        cycle(3'b000, 1, 0, 3'b000, 0);

        // asynchronous reset while out_valid is high
        do_reset();
        cycle(3'b010, 1, 0, 3'b010, 0);
        cycle(3'b000, 1, 0, 3'b000, 0);
        chk("pre_reset_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_out", {out_valid, out_tag, out_source, ru_exp}, '0);
        sb.delete(); s1_pending = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(3'b111, 1, 0, 3'b001, 0);
        cycle(3'b000, 1, 0, 3'b000, 0);
        cycle(3'b000, 1, 0, 3'b000, 1);
        cycle(3'b000, 1, 0, 3'b000, 0);

        // fairness: 2 always valid, 0/1 alternate
        do_reset();
        fair_on = 1'b1;
        cycle(3'b101, 1, 0, 3'b001, 0);
        cycle(3'b110, 1, 0, 3'b010, 0);
        cycle(3'b101, 1, 0, 3'b100, 1);
        cycle(3'b110, 1, 0, 3'b010, 1);
        cycle(3'b101, 1, 0, 3'b100, 1);
        cycle(3'b110, 1, 0, 3'b010, 1);
        fair_on = 1'b0;
        cycle(3'b000, 1, 0, 3'b000, 1);
        cycle(3'b000, 1, 0, 3'b000, 1);
        cycle(3'b000, 1, 0, 3'b000, 0);
        chk("fairness", fair_max <= 2, 1'b1);

        cycle(3'b000, 1, 0, 3'b000, 0);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
